alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares one combinational 64-bit ALU (ADD/SUB/AND/XOR, signed, with overflow) between two requesters, e.g. the execute stage and the address/branch-compare unit. It accepts at most one operation per cycle through valid/ready handshakes and arbitrates round-robin. Each result is registered into a per-requester response slot, with its own valid/ready handshake. A saturating counter tracks overflow events.

## Interface
Parameters:
- W, 64, operand/result width; fixed at 64 by the ALU.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  64  signed operands.
- req0_op  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 is held.
- rsp0_ready  in  1  requester 0 consumes the result.
- rsp0_out  out  64  signed result.
- rsp0_ovf  out  1  overflow flag; 0 for AND/XOR.
- rsp1_valid, rsp1_ready, rsp1_out, rsp1_ovf: same as requester 0, for requester 1.
- ovf_count  out  CNT_W  saturating count of accepted ops that overflowed.

## Operation
- Slot free for requester i: !rspi_valid || rspi_ready. A full slot that is drained in the same cycle is free.
- Eligible requester i: reqi_valid && slot free for i.
- Priority pointer ptr (1 bit), reset value 0.
  - Both eligible: grant ptr.
  - One eligible: grant that one.
  - None eligible: no grant.
- reqi_ready = grant_i. It is combinational from valids, slot state, rsp_ready and ptr. At most one ready is high per cycle.
- On a grant, the ALU inputs are muxed from the granted requester. At the clock edge:
  - rspi_out and rspi_ovf load the ALU result.
  - rspi_valid is set.
  - ptr is set to the requester that was not granted.
- No grant: ptr holds.
- Response slot i with no new grant: rspi_valid clears when rspi_ready is high. Data outputs hold their last value.
- Overflow is valid only for ADD/SUB: signed two's-complement overflow, i.e. operand signs equal and result sign differs (for SUB, compare against the sign of the negated b). AND and XOR force ovf to 0.
- ovf_count increments on each granted op whose ovf is 1. It saturates at 2^CNT_W-1 and does not wrap.
- Requesters must hold a/b/op stable while valid && !ready. The block does not check this.

## Timing
- Reset (synchronous, highest priority): rsp0/1_valid=0, rsp0/1_out=0, rsp0/1_ovf=0, ptr=0, ovf_count=0. reqi_ready evaluates from reset state: a valid with an empty slot sees ready=1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards any held results and the pending grant. Nothing is written on that edge except the reset values.
- Latency: accepted at edge N, rsp valid from edge N through the cycle after.
- Throughput: 1 op/cycle total. With continuous rsp_ready, one requester alone can issue every cycle.
- Simultaneous slot drain and refill on the same edge: the new result overwrites and valid stays 1, with no bubble.
- A slot full with rsp_ready=0 blocks that requester only. The other requester is still granted even if it is lower priority.

## Test plan
- Reset, then req0 ADD a=5, b=7 with rsp0_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp0_out=12, rsp0_ovf=0.
- Both valid every cycle, both rsp_ready=1; req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants alternate 0,1,0,1 starting with 0. Results 7 and 0xFF appear on alternate cycles.
- req1 ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> rsp1_out=0x8000_0000_0000_0000, rsp1_ovf=1, ovf_count=1. Then SUB 0x8000_0000_0000_0000 - 1 -> ovf=1, ovf_count=2.
- rsp0_ready=0 with rsp0 full, both requesters valid, ptr=0 -> req0_ready=0, req1_ready=1. rsp0 data holds. After rsp0_ready rises, req0 is granted on the same cycle.
- Back-to-back req0 AND ops with rsp0_ready=1 -> rsp0_valid stays 1 continuously and rsp0_out updates each cycle.
- Assert reset while both slots are full and ovf_count=3 -> next cycle all valids=0, outs=0, ovf_count=0, ptr=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one combinational signed ALU (ADD/SUB/AND/XOR with overflow)
//   between two requesters. At most one operation is accepted per cycle,
//   chosen round-robin between the requesters that have room in their
//   response slot. Each result is registered into a per-requester response
//   slot with its own valid/ready handshake. A saturating counter records
//   how many accepted operations overflowed.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       synchronous, active-high reset
//   req0_valid / req0_ready     requester 0 operation handshake
//   req0_a, req0_b              requester 0 signed operands (W bits)
//   req0_op                     00 ADD, 01 SUB, 10 AND, 11 XOR
//   req1_*                      same as requester 0, for requester 1
//   rsp0_valid / rsp0_ready     requester 0 response handshake
//   rsp0_out                    requester 0 signed result (W bits)
//   rsp0_ovf                    requester 0 overflow flag (0 for AND/XOR)
//   rsp1_*                      same as requester 0, for requester 1
//   ovf_count                   saturating count of overflowed operations
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [1:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [1:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_out,
    output logic             rsp0_ovf,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_out,
    output logic             rsp1_ovf,

    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_t;

    // Which requester wins when both are eligible in the same cycle.
    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } pri_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pri_t         ptr;

    logic         slot_free0;
    logic         slot_free1;
    logic         elig0;
    logic         elig1;
    logic         grant0;
    logic         grant1;
    logic         grant_any;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_sum;
    logic [W-1:0] alu_diff;
    logic [W-1:0] alu_res;
    logic         alu_ovf;

    // Arbitration. A slot counts as free when it is empty or being drained
    // on this edge, so a requester whose consumer keeps rsp_ready high can
    // issue every cycle. A requester blocked by its own full slot never
    // stalls the other one, regardless of the priority pointer.
    always_comb begin
        slot_free0 = !rsp0_valid || rsp0_ready;
        slot_free1 = !rsp1_valid || rsp1_ready;
        elig0      = req0_valid && slot_free0;
        elig1      = req1_valid && slot_free1;
        grant0     = elig0 && (!elig1 || (ptr == PRI_REQ0));
        grant1     = elig1 && (!elig0 || (ptr == PRI_REQ1));
        grant_any  = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Shared ALU. Operands come from whichever requester was granted; when
    // nothing is granted the result is simply ignored. Signed overflow is
    // flagged when the effective operand signs agree but the result sign
    // differs; for SUB the effective second operand is -b, so the operand
    // signs must differ instead.
    always_comb begin
        alu_a    = grant1 ? req1_a  : req0_a;
        alu_b    = grant1 ? req1_b  : req0_b;
        alu_op   = grant1 ? req1_op : req0_op;
        alu_sum  = alu_a + alu_b;
        alu_diff = alu_a - alu_b;
        alu_res  = alu_sum;
        alu_ovf  = 1'b0;
        case (alu_op_t'(alu_op))
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (alu_a[W-1] == alu_b[W-1]) &&
                          (alu_sum[W-1] != alu_a[W-1]);
            end
            OP_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (alu_a[W-1] != alu_b[W-1]) &&
                          (alu_diff[W-1] != alu_a[W-1]);
            end
            OP_AND: begin
                alu_res = alu_a & alu_b;
                alu_ovf = 1'b0;
            end
            OP_XOR: begin
                alu_res = alu_a ^ alu_b;
                alu_ovf = 1'b0;
            end
            default: begin
                alu_res = alu_sum;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Round-robin pointer: after a grant, the requester that lost gets
    // priority next time. With no grant the pointer keeps its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PRI_REQ0;
        end else if (grant_any) begin
            ptr <= grant0 ? PRI_REQ1 : PRI_REQ0;
        end
    end

    // Response slot 0. A new grant always wins over a drain, so a slot that
    // is consumed and refilled on the same edge keeps valid high with no
    // bubble. The data registers hold their last value once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_ovf   <= 1'b0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_out   <= alu_res;
            rsp0_ovf   <= alu_ovf;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Response slot 1, same behaviour as slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_ovf   <= 1'b0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_out   <= alu_res;
            rsp1_ovf   <= alu_ovf;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    // Overflow event counter. Counts accepted operations whose result
    // overflowed and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (grant_any && alu_ovf && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + CNT_ONE;
        end
    end

endmodule
